// File: rtl/pe_array_pkg.sv
// pe_array_pkg: shared lane constants, fill/hold state and slot mapping for the PE-array selectors
package pe_array_pkg;
  localparam int LANES = 32;
  localparam int SEL_W = 5;
  typedef enum logic {FILL, HOLD} state_t;
  function automatic int lane_lsb(input logic [SEL_W-1:0] sel, input int width = 16);
    return width * (LANES - 1 - int'(sel));
  endfunction
endpackage

// File: rtl/scatter32_dec5to32.sv
// dec5to32: binary lane select to one-hot lane write-enable
module dec5to32
  import pe_array_pkg::*;
(
  input  logic [SEL_W-1:0] i_sel,
  output logic [LANES-1:0] o_onehot
);
  always_comb o_onehot = LANES'(1) << i_sel;
endmodule

// File: rtl/scatter32.sv
// scatter32: assembles WIDTH-bit words into a 32-lane line by lane select, emits on full mask or in_last
module scatter32
  import pe_array_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_data,
  output logic [LANES-1:0]       out_mask
);
  state_t r_state, w_next;
  logic [WIDTH*LANES-1:0] r_data;
  logic [LANES-1:0] r_mask, w_onehot, w_we, w_mask_next;
  logic w_accept, w_xfer;
  dec5to32 u_dec (.i_sel(in_sel), .o_onehot(w_onehot));
  // handshake flags depend only on state (and reset), never on the peer's valid/ready
  always_comb begin
    in_ready    = r_state == FILL && !rst;
    out_valid   = r_state == HOLD && !rst;
    w_accept    = in_valid && in_ready;
    w_xfer      = out_valid && out_ready;
    w_we        = w_onehot & {LANES{w_accept}};
    w_mask_next = r_mask | w_we;
    w_next      = r_state == FILL ? ((w_accept && (in_last || &w_mask_next)) ? HOLD : FILL)
                                  : (out_ready ? FILL : HOLD);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_data  <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      if (w_xfer) begin
        r_data <= '0;
        r_mask <= '0;
      end else begin
        r_mask <= w_mask_next;
        for (int l = 0; l < LANES; l++)
          if (w_we[l]) r_data[lane_lsb(SEL_W'(l), WIDTH) +: WIDTH] <= in_data;
      end
    end
  end
  assign out_data = r_data;
  assign out_mask = r_mask;
endmodule

// File: tb/tb_scatter32.sv
// tb_scatter32: directed vectors with hand-computed expectations for scatter32
module tb_scatter32;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [15:0] in_data = '0;
  logic [4:0] in_sel = '0;
  logic [511:0] out_data;
  logic [31:0] out_mask;
  int n_vec = 0, n_err = 0;
  logic [511:0] exp_line, held;
  scatter32 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mask(out_mask)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [4:0] s, input logic [15:0] d, input logic l);
    in_valid = 1; in_sel = s; in_data = d; in_last = l;
    tick();
    in_valid = 0; in_last = 0;
  endtask
  task automatic drain();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask
  // read-side 32:1 selector model: select s reads the slot holding bits [16*(32-s)-1 : 16*(31-s)]
  function automatic logic [15:0] rd_sel(input logic [511:0] line, input int s);
    return line[16*(31-s) +: 16];
  endfunction
  initial begin
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mask", out_mask, 0);
    rst = 0;
    #1;
    chk("first_in_ready", in_ready, 1);
    for (int s = 0; s < 32; s++) begin
      chk("fill_ready", in_ready, 1);
      chk("fill_no_valid", out_valid, 0);
      put(5'(s), 16'h1000 + 16'(s), 0);
    end
    chk("full_valid", out_valid, 1);
    chk("full_mask", out_mask, 32'hFFFF_FFFF);
    chk("full_lsw", out_data[15:0], 16'h101F);
    chk("full_msw", out_data[511:496], 16'h1000);
    chk("full_ready", in_ready, 0);
    for (int s = 0; s < 32; s++) chk("roundtrip", rd_sel(out_data, s), 16'h1000 + 16'(s));
    held = out_data;
    in_valid = 1; in_sel = 5'd3; in_data = 16'hFFFF; in_last = 1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_data", out_data, held);
      chk("bp_mask", out_mask, 32'hFFFF_FFFF);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("xfer_valid", out_valid, 0);
    chk("xfer_mask", out_mask, 0);
    chk("xfer_data", out_data, 0);
    chk("xfer_ready", in_ready, 1);
    in_valid = 0; in_last = 0;
    out_ready = 1;
    tick();
    out_ready = 0;
    chk("fill_oready_ignored", out_valid, 0);
    in_last = 1;
    tick();
    in_last = 0;
    chk("last_no_valid", out_valid, 0);
    put(5'd31, 16'hBEEF, 0);
    chk("early_partial", out_valid, 0);
    put(5'd5, 16'h1234, 1);
    exp_line = '0;
    exp_line[15:0] = 16'hBEEF;
    exp_line[431:416] = 16'h1234;
    chk("early_valid", out_valid, 1);
    chk("early_mask", out_mask, 32'h8000_0020);
    chk("early_data", out_data, exp_line);
    drain();
    put(5'd7, 16'hAAAA, 0);
    put(5'd7, 16'h5555, 1);
    exp_line = '0;
    exp_line[399:384] = 16'h5555;
    chk("ovw_valid", out_valid, 1);
    chk("ovw_mask", out_mask, 32'h0000_0080);
    chk("ovw_data", out_data, exp_line);
    drain();
    for (int s = 0; s < 10; s++) put(5'(s), 16'h2000 + 16'(s), 0);
    chk("mid_mask", out_mask, 32'h0000_03FF);
    rst = 1;
    #1;
    chk("mid_rst_ready", in_ready, 0);
    tick();
    rst = 0;
    for (int c = 0; c < 4; c++) begin
      chk("mid_no_valid", out_valid, 0);
      chk("mid_data", out_data, 0);
      chk("mid_mask0", out_mask, 0);
      tick();
    end
    put(5'd0, 16'h4242, 1);
    exp_line = '0;
    exp_line[511:496] = 16'h4242;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_mask", out_mask, 32'h0000_0001);
    chk("post_rst_data", out_data, exp_line);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
